multimode_counter: RTL and testbench

- Parametrised successor to the team's 3-bit binary/Gray mode counter.
- Keeps a binary sequence index with modulus MODULUS. The index counts up or down, can be enabled or held, and can be loaded synchronously.
- Count presents the index as binary or as reflected Gray code, selected by M. The sequence position is kept when the mode changes.
- Tc flags wrap events. Used as a sequencer and address generator in the lab datapaths.

---
 rtl/multimode_counter.sv | 103 ++++++++++
 tb/tb_multimode_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_counter.sv
// Modulo-MODULUS up/down counter with binary or Gray coded output, sync load and wrap flag.
// Define MULTIMODE_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module multimode_counter #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 8,
  parameter int RESET_INDEX = 0
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             En,
  input  logic             Up,
  input  logic             M,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] Index,
  output logic             Tc
);

  // Compares run one bit wider so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_IDX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_IDX = WIDTH'(RESET_INDEX);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("multimode_counter: WIDTH %0d outside 2..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("multimode_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  if (RESET_INDEX < 0 || RESET_INDEX >= MODULUS) begin : g_bad_reset_index
    $error("multimode_counter: RESET_INDEX %0d not below MODULUS", RESET_INDEX);
  end

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] idx, input logic gray);
    encode = gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  logic [WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   idx_ext;

  always_comb begin
    idx_ext = {1'b0, index_q};
    index_d = index_q;
    tc_d    = 1'b0;
    if (Load) begin
      index_d = ({1'b0, LoadVal} < MOD_EXT) ? LoadVal : '0;
    end else if (idx_ext > MAX_EXT) begin
      index_d = '0;
    end else if (En) begin
      if (Up) begin
        if (index_q == MAX_IDX) begin
`ifdef MULTIMODE_COUNTER_SAT_EN
          index_d = index_q;
`else
          index_d = '0;
          tc_d    = 1'b1;
`endif
        end else begin
          index_d = index_q + WIDTH'(1);
`ifdef MULTIMODE_COUNTER_SAT_EN
          tc_d    = (index_d == MAX_IDX);
`endif
        end
      end else begin
        if (index_q == '0) begin
`ifdef MULTIMODE_COUNTER_SAT_EN
          index_d = index_q;
`else
          index_d = MAX_IDX;
          tc_d    = 1'b1;
`endif
        end else begin
          index_d = index_q - WIDTH'(1);
`ifdef MULTIMODE_COUNTER_SAT_EN
          tc_d    = (index_d == '0);
`endif
        end
      end
    end
    count_d = encode(index_d, M);
  end

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      index_q <= RST_IDX;
      count_q <= RST_IDX;
      tc_q    <= 1'b0;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign Index = index_q;
  assign Count = count_q;
  assign Tc    = tc_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: vector table, hand sequences and randomized model comparison
// across three parameter sets (8, 6 and 16 positions).
module tb_multimode_counter;

  logic Clk, nReset;
  logic ld_a, en_a, up_a, m_a, tc_a;
  logic ld_b, en_b, up_b, m_b, tc_b;
  logic ld_c, en_c, up_c, m_c, tc_c;
  logic [2:0] lv_a, cnt_a, idx_a;
  logic [2:0] lv_b, cnt_b, idx_b;
  logic [3:0] lv_c, cnt_c, idx_c;

  int n_tests = 0;
  int n_fail  = 0;
  int mods[3] = '{8, 6, 16};
  int rsts[3] = '{0, 0, 3};
  int midx[3];

  multimode_counter #(.WIDTH(3), .MODULUS(8), .RESET_INDEX(0)) u_a (
    .Clk(Clk), .nReset(nReset), .En(en_a), .Up(up_a), .M(m_a), .Load(ld_a),
    .LoadVal(lv_a), .Count(cnt_a), .Index(idx_a), .Tc(tc_a));
  multimode_counter #(.WIDTH(3), .MODULUS(6), .RESET_INDEX(0)) u_b (
    .Clk(Clk), .nReset(nReset), .En(en_b), .Up(up_b), .M(m_b), .Load(ld_b),
    .LoadVal(lv_b), .Count(cnt_b), .Index(idx_b), .Tc(tc_b));
  multimode_counter #(.WIDTH(4), .MODULUS(16), .RESET_INDEX(3)) u_c (
    .Clk(Clk), .nReset(nReset), .En(en_c), .Up(up_c), .M(m_c), .Load(ld_c),
    .LoadVal(lv_c), .Count(cnt_c), .Index(idx_c), .Tc(tc_c));

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit ld; int lv; bit en; bit up; bit m;
    int idx; int cnt; bit tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit ld, int lv, bit en, bit up, bit m, int idx, int cnt, bit tc);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.up = up; v.m = m;
    v.idx = idx; v.cnt = cnt; v.tc = tc;
    return v;
  endfunction

  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction

  // Reference: plain integer arithmetic on the sequence position.
  task automatic model_step(input int idx, input bit ld, input int lv, input bit en,
                            input bit up, input int mod, output int nidx, output bit tc);
    tc   = 1'b0;
    nidx = idx;
    if (ld) begin
      nidx = (lv < mod) ? lv : 0;
    end else if (en) begin
      nidx = up ? idx + 1 : idx - 1;
`ifdef MULTIMODE_COUNTER_SAT_EN
      if (nidx > mod - 1) nidx = mod - 1;
      if (nidx < 0) nidx = 0;
      tc = (nidx != idx) && ((up && nidx == mod - 1) || (!up && nidx == 0));
`else
      if (nidx >= mod) begin nidx = 0; tc = 1'b1; end
      else if (nidx < 0) begin nidx = mod - 1; tc = 1'b1; end
`endif
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input int exp);
    n_tests++;
    if (act !== 16'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input bit l, input int v, input bit e, input bit u, input bit mm);
    case (d)
      0: begin ld_a = l; lv_a = 3'(v); en_a = e; up_a = u; m_a = mm; end
      1: begin ld_b = l; lv_b = 3'(v); en_b = e; up_b = u; m_b = mm; end
      default: begin ld_c = l; lv_c = 4'(v); en_c = e; up_c = u; m_c = mm; end
    endcase
  endtask

  function automatic logic [15:0] get_idx(int d);
    case (d)
      0: return {13'd0, idx_a};
      1: return {13'd0, idx_b};
      default: return {12'd0, idx_c};
    endcase
  endfunction

  function automatic logic [15:0] get_cnt(int d);
    case (d)
      0: return {13'd0, cnt_a};
      1: return {13'd0, cnt_b};
      default: return {12'd0, cnt_c};
    endcase
  endfunction

  function automatic logic [15:0] get_tc(int d);
    case (d)
      0: return {15'd0, tc_a};
      1: return {15'd0, tc_b};
      default: return {15'd0, tc_c};
    endcase
  endfunction

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_idx%0d", tag, d), get_idx(d), rsts[d]);
      check($sformatf("%s_cnt%0d", tag, d), get_cnt(d), rsts[d]);
      check($sformatf("%s_tc%0d", tag, d), get_tc(d), 0);
    end
  endtask

  initial begin
    bit rl[3], re[3], ru[3], rm[3];
    int rv[3];
    int nidx;
    bit ntc;

`ifdef MULTIMODE_COUNTER_SAT_EN
    tbl.push_back(mk(1, 5, 0, 0, 0, 5, 5, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 6, 6, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7, 7, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7, 7, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7, 7, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 6, 6, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6, 5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 5, 7, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 4, 6, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 3, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6, 0, 0, 0, 6, 6, 0));
`else
    for (int i = 1; i <= 9; i++)
      tbl.push_back(mk(0, 0, 1, 1, 0, i % 8, i % 8, i == 8));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 2, 3, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3, 2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 4, 6, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 5, 7, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 6, 5, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 7, 4, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 5, 0, 0, 0, 5, 5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 7, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 4, 6, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 3, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 7, 4, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 6, 1, 1, 0, 6, 6, 0));
`endif

    nReset = 1'b1;
    for (int d = 0; d < 3; d++) set_in(d, 0, 0, 0, 0, 0);
    #1 nReset = 1'b0;
    #1 check_reset("reset");
    #1 nReset = 1'b1;

    foreach (tbl[i]) begin
      set_in(0, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up, tbl[i].m);
      step();
      check($sformatf("tbl%0d_idx", i), get_idx(0), tbl[i].idx);
      check($sformatf("tbl%0d_cnt", i), get_cnt(0), tbl[i].cnt);
      check($sformatf("tbl%0d_tc", i), get_tc(0), tbl[i].tc);
    end

    // Asynchronous reset mid-cycle while counting from 6.
    set_in(0, 0, 0, 1, 1, 0);
    #3 nReset = 1'b0;
    #1 check_reset("async");
    #1 nReset = 1'b1;
    step();
    check("resume_idx", get_idx(0), 1);
    check("resume_cnt", get_cnt(0), 1);
    set_in(0, 0, 0, 0, 0, 0);

    // Six-position counter: down from 0, out-of-range load, load over enable.
    set_in(1, 0, 0, 1, 0, 0);
    step();
`ifdef MULTIMODE_COUNTER_SAT_EN
    check("m6_down_idx", get_idx(1), 0);
    check("m6_down_tc", get_tc(1), 0);
`else
    check("m6_down_idx", get_idx(1), 5);
    check("m6_down_tc", get_tc(1), 1);
`endif
    set_in(1, 1, 7, 0, 0, 0);
    step();
    check("m6_load7_idx", get_idx(1), 0);
    check("m6_load7_tc", get_tc(1), 0);
    set_in(1, 1, 3, 1, 1, 0);
    step();
    check("m6_load_en_idx", get_idx(1), 3);
    check("m6_load_en_tc", get_tc(1), 0);

    // Randomized run against the reference model.
    for (int d = 0; d < 3; d++) set_in(d, 0, 0, 0, 0, 0);
    #3 nReset = 1'b0;
    #1 nReset = 1'b1;
    for (int d = 0; d < 3; d++) midx[d] = rsts[d];
    for (int it = 0; it < 600; it++) begin
      for (int d = 0; d < 3; d++) begin
        rl[d] = ($urandom_range(0, 7) == 0);
        rv[d] = $urandom_range(0, (d == 2) ? 15 : 7);
        re[d] = ($urandom_range(0, 3) != 0);
        ru[d] = 1'($urandom_range(0, 1));
        rm[d] = 1'($urandom_range(0, 1));
        set_in(d, rl[d], rv[d], re[d], ru[d], rm[d]);
      end
      step();
      for (int d = 0; d < 3; d++) begin
        model_step(midx[d], rl[d], rv[d], re[d], ru[d], mods[d], nidx, ntc);
        midx[d] = nidx;
        check($sformatf("rnd%0d_d%0d_idx", it, d), get_idx(d), nidx);
        check($sformatf("rnd%0d_d%0d_cnt", it, d), get_cnt(d), rm[d] ? gray(nidx) : nidx);
        check($sformatf("rnd%0d_d%0d_tc", it, d), get_tc(d), int'(ntc));
      end
      if ($urandom_range(0, 39) == 0) begin
        #2 nReset = 1'b0;
        #1 check_reset($sformatf("rnd%0d_rst", it));
        #1 nReset = 1'b1;
        for (int d = 0; d < 3; d++) midx[d] = rsts[d];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
